// File: rtl/fetch_unit.sv
// Instruction fetch: in-order imem word reads into a credit-limited prefetch FIFO that feeds the decoder.
// Latency: grant in N -> rvalid N+1 -> dec_enable N+2; a redirect restarts fetch at the target the next cycle.
// Backpressure: dec_ready=0 holds the head; imem_req drops once outstanding+buffered reaches FIFO_DEPTH.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_enable,
    input  logic        dec_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
);
    localparam int              CW      = $clog2(FIFO_DEPTH + 1);
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam logic [31:0]     NOP     = 32'h0000_0013;
    localparam logic [CW:0]     DEPTH_C = FIFO_DEPTH[CW:0];
    localparam logic [CW-1:0]   FULL    = FIFO_DEPTH[CW-1:0];

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop;
    logic [31:0]     fetch_pc;
    logic [31:0]     resp_pc;
    logic [31:0]     target;
    logic            grant;
    logic            discard;
    logic            push;
    logic            pop;

    assign target    = redirect_target & ~32'h3;

    // Credit covers both in-flight and buffered words so a response always has a slot.
    assign imem_req  = rst_n && !redirect_valid &&
                       (({1'b0, outstanding} + {1'b0, count}) < DEPTH_C);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign discard   = imem_rvalid && (drop != '0);
    assign push      = imem_rvalid && !discard && !redirect_valid;

    assign dec_enable = (count != '0);
    assign pop        = dec_enable && dec_ready && !redirect_valid;
    assign dec_instr  = dec_enable ? fifo_mem[rd_ptr].instr : NOP;
    assign dec_pc     = dec_enable ? fifo_mem[rd_ptr].pc    : resp_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);
            if (redirect_valid) begin
                // Everything still in flight is stale, except a response landing right now.
                fetch_pc <= target;
                resp_pc  <= target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                drop     <= outstanding - CW'(imem_rvalid);
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (discard) begin
                    drop <= drop - CW'(1);
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + PW'(1);
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            assert (count != FULL);
            fifo_mem[wr_ptr] <= '{pc: resp_pc, instr: imem_rdata};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with per-request latency, epoch-based
// reference for which words reach the decoder, plus a second instance for PC wrap-around.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] W_RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, imem_req, imem_gnt, imem_rvalid, dec_enable, dec_ready, redirect_valid;
    logic [31:0] imem_addr, imem_rdata, dec_instr, dec_pc, redirect_target;
    logic        w_rst_n, w_req, w_rvalid, w_en;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_enable(dec_enable), .dec_ready(dec_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target)
    );

    fetch_unit #(.RESET_PC(W_RST_PC), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .dec_instr(w_instr), .dec_pc(w_pc), .dec_enable(w_en), .dec_ready(1'b1),
        .redirect_valid(1'b0), .redirect_target(32'h0)
    );

    typedef struct {
        logic [31:0] pc;
        int          due;
        int          ep;
    } req_t;

    req_t        mq[$];
    int          cyc = 0;
    int          ep = 0;
    int          n_pass = 0;
    int          n_checks = 0;
    bit          model_valid = 0;
    int          buffered = 0;
    logic [31:0] exp_pc, exp_fetch;
    logic [31:0] deliv[$];
    logic [31:0] w_deliv[$];
    logic [31:0] w_ideliv[$];

    logic        rst_drive, w_rst_drive, gnt_rand, redir_go;
    logic [31:0] redir_tgt;
    int          rdy_mode, lat_lo, lat_hi;

    logic        obs_req, obs_gnt, obs_en, obs_rvalid;
    logic [31:0] obs_addr, obs_pc, obs_instr;
    int          obs_cyc;
    logic        w_pend;
    logic [31:0] w_pend_dat;

    // One clock cycle: drive at negedge, sample and score 3ns later, advance the model at the edge.
    task automatic step();
        logic exp_req, exp_en;
        logic [31:0] exp_i;
        req_t e;
        @(negedge clk);
        rst_n   = rst_drive;
        w_rst_n = w_rst_drive;
        dec_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        redirect_valid  = redir_go;
        redirect_target = redir_tgt;
        redir_go = 1'b0;
        imem_gnt = gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mq[0].pc >> 2;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        w_rvalid = w_pend;
        w_rdata  = w_pend_dat;
        #3;
        obs_req = imem_req; obs_gnt = imem_gnt; obs_en = dec_enable; obs_rvalid = imem_rvalid;
        obs_addr = imem_addr; obs_pc = dec_pc; obs_instr = dec_instr; obs_cyc = cyc;
        if (rst_n && dec_enable && dec_ready && !redirect_valid) deliv.push_back(dec_pc);
        if (w_rst_n && w_en) begin
            w_deliv.push_back(w_pc);
            w_ideliv.push_back(w_instr);
        end
        w_pend     = w_rst_n && w_req;
        w_pend_dat = w_addr >> 2;
        exp_req = 1'b0;
        if (model_valid) begin
            exp_en  = (buffered != 0);
            exp_req = rst_n && !redirect_valid && (mq.size() + buffered < DEPTH);
            exp_i   = exp_en ? (exp_pc >> 2) : NOP;
            n_checks++;
            if (dec_enable !== exp_en) $display("FAIL sb_enable cyc=%0d got %b exp %b", cyc, dec_enable, exp_en);
            else n_pass++;
            n_checks++;
            if (dec_pc !== exp_pc) $display("FAIL sb_pc cyc=%0d got %h exp %h", cyc, dec_pc, exp_pc);
            else n_pass++;
            n_checks++;
            if (dec_instr !== exp_i) $display("FAIL sb_instr cyc=%0d got %h exp %h", cyc, dec_instr, exp_i);
            else n_pass++;
            n_checks++;
            if (imem_req !== exp_req) $display("FAIL sb_req cyc=%0d got %b exp %b", cyc, imem_req, exp_req);
            else n_pass++;
            if (exp_req) begin
                n_checks++;
                if (imem_addr !== exp_fetch) $display("FAIL sb_addr cyc=%0d got %h exp %h", cyc, imem_addr, exp_fetch);
                else n_pass++;
            end
        end
        if (!rst_n) begin
            mq.delete();
            buffered = 0; exp_pc = RST_PC; exp_fetch = RST_PC; ep++; model_valid = 1;
        end else if (model_valid) begin
            if (buffered != 0 && dec_ready && !redirect_valid) begin
                exp_pc += 32'd4;
                buffered--;
            end
            if (imem_rvalid) begin
                e = mq.pop_front();
                if (e.ep == ep && !redirect_valid) buffered++;
            end
            if (exp_req && imem_gnt) begin
                mq.push_back('{pc: exp_fetch, due: cyc + int'($urandom_range(lat_lo, lat_hi)), ep: ep});
                exp_fetch += 32'd4;
            end
            if (redirect_valid) begin
                ep++;
                buffered  = 0;
                exp_pc    = redirect_target & ~32'h3;
                exp_fetch = redirect_target & ~32'h3;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        int g;
        bit seen;
        rst_drive = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (obs_req !== 1'b0) $display("FAIL reset_req_low got %b exp 0", obs_req);
            else n_pass++;
        end
        n_checks++;
        if (obs_en !== 1'b0 || obs_instr !== NOP || obs_pc !== RST_PC)
            $display("FAIL reset_outputs got en=%b instr=%h pc=%h exp 0/%h/%h", obs_en, obs_instr, obs_pc, NOP, RST_PC);
        else n_pass++;
        deliv.delete();
        rst_drive = 1'b1;
        step();
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== RST_PC)
            $display("FAIL release_req got req=%b addr=%h exp 1/%h", obs_req, obs_addr, RST_PC);
        else n_pass++;
        g = obs_cyc;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (obs_en === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen || obs_cyc != g + 2) $display("FAIL first_enable_latency got %0d cycles exp 2 (seen=%0d)", obs_cyc - g, seen);
        else n_pass++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 16; i++) step();
        n_checks++;
        if (deliv.size() != 17) $display("FAIL stream_count got %0d exp 17", deliv.size());
        else n_pass++;
        for (int i = 0; i < deliv.size() && i < 17; i++) begin
            n_checks++;
            if (deliv[i] !== 32'(4 * i)) $display("FAIL stream_pc[%0d] got %h exp %h", i, deliv[i], 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_stall();
        int grants;
        rst_drive = 1'b0;
        step();
        step();
        rst_drive = 1'b1;
        rdy_mode  = 1;
        grants    = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_req && obs_gnt) grants++;
        end
        n_checks++;
        if (grants != DEPTH) $display("FAIL stall_grants got %0d exp %0d", grants, DEPTH);
        else n_pass++;
        n_checks++;
        if (obs_req !== 1'b0 || obs_en !== 1'b1 || obs_pc !== RST_PC)
            $display("FAIL stall_hold got req=%b en=%b pc=%h exp 0/1/%h", obs_req, obs_en, obs_pc, RST_PC);
        else n_pass++;
        rdy_mode = 0;
        deliv.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (obs_en !== 1'b1) $display("FAIL release_gap step %0d got en=%b exp 1", i, obs_en);
            else n_pass++;
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= deliv.size() || deliv[i] !== RST_PC + 32'(4 * i))
                $display("FAIL release_pc[%0d] got %h exp %h", i, (i < deliv.size()) ? deliv[i] : 32'hx, RST_PC + 32'(4 * i));
            else n_pass++;
        end
    endtask

    task automatic test_redirect(input bit coincide);
        bit found;
        logic [31:0] tgt;
        tgt    = coincide ? 32'h0000_0102 : 32'h0000_0100;
        lat_lo = coincide ? 3 : 4;
        lat_hi = lat_lo;
        found  = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (mq.size() == 3 && ((mq[0].due <= cyc) == coincide)) found = 1;
            else step();
        end
        n_checks++;
        if (!found) $display("FAIL redir_setup coincide=%0d got no 3-outstanding cycle exp one", coincide);
        else n_pass++;
        redir_go  = 1'b1;
        redir_tgt = tgt;
        step();
        n_checks++;
        if (obs_rvalid !== coincide) $display("FAIL redir_rvalid got %b exp %b", obs_rvalid, coincide);
        else n_pass++;
        deliv.delete();
        step();
        n_checks++;
        if (obs_en !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h100)
            $display("FAIL redir_r1 got en=%b req=%b addr=%h exp 0/1/00000100", obs_en, obs_req, obs_addr);
        else n_pass++;
        for (int i = 0; i < 20 && deliv.size() == 0; i++) step();
        n_checks++;
        if (deliv.size() == 0 || deliv[0] !== 32'h100)
            $display("FAIL redir_first_pc got %h exp 00000100", (deliv.size() != 0) ? deliv[0] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_b2b();
        int bad;
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 5; i++) step();
        deliv.delete();
        redir_go = 1'b1; redir_tgt = 32'h200;
        step();
        redir_go = 1'b1; redir_tgt = 32'h300;
        step();
        for (int i = 0; i < 30 && deliv.size() < 4; i++) step();
        n_checks++;
        if (deliv.size() == 0 || deliv[0] !== 32'h300)
            $display("FAIL b2b_first_pc got %h exp 00000300", (deliv.size() != 0) ? deliv[0] : 32'hx);
        else n_pass++;
        bad = 0;
        foreach (deliv[i]) if (deliv[i] >= 32'h200 && deliv[i] < 32'h300) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL b2b_stale got %0d words from 0x200 exp 0", bad);
        else n_pass++;
    endtask

    task automatic test_midreset();
        lat_lo = 1; lat_hi = 1;
        rdy_mode = 1;
        for (int i = 0; i < 12 && buffered != 3; i++) step();
        n_checks++;
        if (obs_en !== 1'b1 || buffered != 3) $display("FAIL midrst_setup got en=%b buffered=%0d exp 1/3", obs_en, buffered);
        else n_pass++;
        rst_drive = 1'b0;
        step();
        n_checks++;
        if (obs_req !== 1'b0) $display("FAIL midrst_req got %b exp 0", obs_req);
        else n_pass++;
        step();
        n_checks++;
        if (obs_en !== 1'b0 || obs_req !== 1'b0) $display("FAIL midrst_next got en=%b req=%b exp 0/0", obs_en, obs_req);
        else n_pass++;
        rst_drive = 1'b1;
        rdy_mode  = 0;
        deliv.delete();
        step();
        n_checks++;
        if (obs_req !== 1'b1 || obs_addr !== RST_PC) $display("FAIL midrst_restart got req=%b addr=%h exp 1/%h", obs_req, obs_addr, RST_PC);
        else n_pass++;
        for (int i = 0; i < 10 && deliv.size() == 0; i++) step();
        n_checks++;
        if (deliv.size() == 0 || deliv[0] !== RST_PC)
            $display("FAIL midrst_first_pc got %h exp %h", (deliv.size() != 0) ? deliv[0] : 32'hx, RST_PC);
        else n_pass++;
    endtask

    task automatic test_random();
        gnt_rand = 1'b1; rdy_mode = 2; lat_lo = 1; lat_hi = 4;
        deliv.delete();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 24) == 0) begin
                redir_go  = 1'b1;
                redir_tgt = $urandom;
            end
            step();
        end
        n_checks++;
        if (deliv.size() < 100) $display("FAIL rand_progress got %0d deliveries exp >=100", deliv.size());
        else n_pass++;
        gnt_rand = 1'b0; rdy_mode = 0; lat_lo = 1; lat_hi = 1;
    endtask

    task automatic test_wrap();
        logic [31:0] e;
        w_rst_drive = 1'b0;
        step();
        step();
        w_deliv.delete();
        w_ideliv.delete();
        w_rst_drive = 1'b1;
        for (int i = 0; i < 8; i++) step();
        n_checks++;
        if (w_deliv.size() < 5) $display("FAIL wrap_count got %0d exp >=5", w_deliv.size());
        else n_pass++;
        for (int i = 0; i < 5 && i < w_deliv.size(); i++) begin
            e = W_RST_PC + 32'(4 * i);
            n_checks++;
            if (w_deliv[i] !== e || w_ideliv[i] !== (e >> 2))
                $display("FAIL wrap_pc[%0d] got pc=%h instr=%h exp %h/%h", i, w_deliv[i], w_ideliv[i], e, e >> 2);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        dec_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        w_rst_n = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_pend = 1'b0; w_pend_dat = '0;
        rst_drive = 1'b0; w_rst_drive = 1'b0; gnt_rand = 1'b0; redir_go = 1'b0; redir_tgt = '0;
        rdy_mode = 0; lat_lo = 1; lat_hi = 1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect(1'b0);
        test_redirect(1'b1);
        test_b2b();
        test_midreset();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
